// File: rtl/wb_mem_arbiter.sv
// Wishbone arbiter feeding one SDRAM port from a buffered ioctl loader and
// up to four core masters (round-robin, burst hold on incrementing CTI).
module wb_mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 26,
  parameter int DW          = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk_sys,
  input  logic                            reset_n,
  input  logic                            ioctl_download,
  input  logic                            ioctl_wr,
  input  logic [AW-1:0]                   ioctl_addr,
  input  logic [DW-1:0]                   ioctl_dout,
  input  logic [DW/8-1:0]                 ioctl_sel,
  output logic                            ioctl_wait,
  output logic                            loader_ovf,
  output logic                            download_done,
  input  logic [NUM_MASTERS-1:0]          m_stb,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS*(DW/8)-1:0]   m_sel,
  input  logic [NUM_MASTERS*AW-1:0]       m_adr,
  input  logic [NUM_MASTERS*DW-1:0]       m_dat_o,
  input  logic [NUM_MASTERS*3-1:0]        m_cti,
  output logic [NUM_MASTERS-1:0]          m_ack,
  output logic [DW-1:0]                   m_dat_i,
  output logic                            s_stb,
  output logic                            s_cyc,
  output logic                            s_we,
  output logic [DW/8-1:0]                 s_sel,
  output logic [AW-1:0]                   s_adr,
  output logic [DW-1:0]                   s_dat_o,
  output logic [2:0]                      s_cti,
  input  logic                            s_ack,
  input  logic [DW-1:0]                   s_dat_i
);

  localparam int SW = DW / 8;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [2:0] CTI_INCR = 3'b010;

  typedef enum logic [1:0] {ST_IDLE, ST_LOADER, ST_MASTER} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   grant_reg, grant_next;

  logic [AW-1:0]   fifo_adr_mem [FIFO_DEPTH];
  logic [DW-1:0]   fifo_dat_mem [FIFO_DEPTH];
  logic [SW-1:0]   fifo_sel_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic            ioctl_wait_reg, ovf_reg, dl_flag_reg;
  logic            fifo_empty, fifo_full, push, pop;

  logic [AW-1:0]   mst_adr [NUM_MASTERS];
  logic [DW-1:0]   mst_dat [NUM_MASTERS];
  logic [SW-1:0]   mst_sel [NUM_MASTERS];
  logic [2:0]      mst_cti [NUM_MASTERS];

  logic            rr_found;
  logic [GW-1:0]   rr_pick;
  logic [AW-1:0]   adr_mux;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
      assign mst_adr[gi] = m_adr[gi*AW +: AW];
      assign mst_dat[gi] = m_dat_o[gi*DW +: DW];
      assign mst_sel[gi] = m_sel[gi*SW +: SW];
      assign mst_cti[gi] = m_cti[gi*3 +: 3];
      assign m_ack[gi]   = (state_reg == ST_MASTER) && (grant_reg == GW'(gi)) && s_ack;
    end
  endgenerate

  // ---------------- loader FIFO ----------------
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
  assign push       = ioctl_wr && !fifo_full;
  assign pop        = (state_reg == ST_LOADER) && s_ack;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (!push && pop) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_adr_mem[wr_ptr_reg] <= ioctl_addr;
      fifo_dat_mem[wr_ptr_reg] <= ioctl_dout;
      fifo_sel_mem[wr_ptr_reg] <= ioctl_sel;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      ioctl_wait_reg <= 1'b0;
      ovf_reg        <= 1'b0;
      dl_flag_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
      // Asserted one entry early so a write already in flight still fits.
      ioctl_wait_reg <= (count_next >= CW'(FIFO_DEPTH - 1));
      if (ioctl_wr && fifo_full) ovf_reg <= 1'b1;
      if (ioctl_download) begin
        dl_flag_reg <= 1'b1;
      end else if (download_done) begin
        dl_flag_reg <= 1'b0;
      end
    end
  end

  assign ioctl_wait    = ioctl_wait_reg;
  assign loader_ovf    = ovf_reg;
  assign download_done = dl_flag_reg && !ioctl_download && fifo_empty && (state_reg == ST_IDLE);

  // ---------------- round-robin pick ----------------
  always_comb begin
    int idx;
    rr_found = 1'b0;
    rr_pick  = grant_reg;
    idx      = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(grant_reg) + k) % NUM_MASTERS;
      if (!rr_found && m_stb[GW'(idx)]) begin
        rr_found = 1'b1;
        rr_pick  = GW'(idx);
      end
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      grant_reg <= GW'(NUM_MASTERS - 1);
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next = ST_LOADER;
        end else if (!ioctl_download && rr_found) begin
          state_next = ST_MASTER;
          grant_next = rr_pick;
        end
      end
      ST_LOADER: begin
        if (s_ack && (count_reg <= CW'(1))) state_next = ST_IDLE;
      end
      ST_MASTER: begin
        if (!m_stb[grant_reg]) begin
          state_next = ST_IDLE;
        end else if (s_ack && (mst_cti[grant_reg] != CTI_INCR)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- slave port mux ----------------
  always_comb begin
    s_stb   = 1'b0;
    s_cyc   = 1'b0;
    s_we    = 1'b0;
    s_sel   = '0;
    adr_mux = '0;
    s_dat_o = '0;
    s_cti   = 3'b000;
    case (state_reg)
      ST_LOADER: begin
        s_stb   = 1'b1;
        s_cyc   = 1'b1;
        s_we    = 1'b1;
        s_sel   = fifo_sel_mem[rd_ptr_reg];
        adr_mux = fifo_adr_mem[rd_ptr_reg];
        s_dat_o = fifo_dat_mem[rd_ptr_reg];
      end
      ST_MASTER: begin
        s_stb   = 1'b1;
        s_cyc   = 1'b1;
        s_we    = m_we[grant_reg];
        s_sel   = mst_sel[grant_reg];
        adr_mux = mst_adr[grant_reg];
        s_dat_o = mst_dat[grant_reg];
        s_cti   = mst_cti[grant_reg];
      end
      default: ;
    endcase
  end

  // Addresses are always word-aligned on the SDRAM side.
  assign s_adr   = adr_mux & ~AW'(SW - 1);
  assign m_dat_i = s_dat_i;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Scoreboard bench for wb_mem_arbiter: a slave model acks, a monitor pops
// expected slave transactions, directed tests push them.
module tb_wb_mem_arbiter;

  localparam int NM = 2;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam logic [DW-1:0] RD_DATA = 32'hCAFEF00D;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic          we;
    logic [SW-1:0] sel;
    logic [2:0]    cti;
  } beat_t;

  typedef struct packed {
    beat_t         b;
    logic [NM-1:0] ack;
  } txn_t;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic              reset_n, ioctl_download, ioctl_wr;
  logic [AW-1:0]     ioctl_addr;
  logic [DW-1:0]     ioctl_dout;
  logic [SW-1:0]     ioctl_sel;
  logic              ioctl_wait, loader_ovf, download_done;
  logic [NM-1:0]     m_stb, m_we, m_ack;
  logic [NM*SW-1:0]  m_sel;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat_o;
  logic [NM*3-1:0]   m_cti;
  logic [DW-1:0]     m_dat_i;
  logic              s_stb, s_cyc, s_we, s_ack;
  logic [SW-1:0]     s_sel;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat_o, s_dat_i;
  logic [2:0]        s_cti;

  wb_mem_arbiter #(.NUM_MASTERS(NM), .AW(AW), .DW(DW), .FIFO_DEPTH(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_sel(ioctl_sel), .ioctl_wait(ioctl_wait),
    .loader_ovf(loader_ovf), .download_done(download_done),
    .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel), .m_adr(m_adr), .m_dat_o(m_dat_o),
    .m_cti(m_cti), .m_ack(m_ack), .m_dat_i(m_dat_i),
    .s_stb(s_stb), .s_cyc(s_cyc), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr),
    .s_dat_o(s_dat_o), .s_cti(s_cti), .s_ack(s_ack), .s_dat_i(s_dat_i)
  );

  txn_t  exp_q[$];
  beat_t mq0[$];
  beat_t mq1[$];
  int    hs_cyc_q[$];
  int    checks = 0;
  int    passes = 0;
  int    hs_cnt = 0;
  int    done_cnt = 0;
  int    cyc = 0;
  logic  ack_en = 1'b0;
  logic [NM-1:0] m_ack_seen = '0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic beat_t mk(logic [AW-1:0] a, logic [DW-1:0] d, logic we,
                               logic [SW-1:0] sel, logic [2:0] cti);
    beat_t b;
    b.adr = a; b.dat = d; b.we = we; b.sel = sel; b.cti = cti;
    return b;
  endfunction

  function automatic void expect_txn(beat_t b, logic [NM-1:0] ack);
    txn_t t;
    t.b = b; t.ack = ack;
    exp_q.push_back(t);
  endfunction

  function automatic logic [127:0] all_outs();
    return 128'({ioctl_wait, loader_ovf, download_done, m_ack, s_stb, s_cyc, s_we,
                 s_sel, s_adr, s_dat_o, s_cti});
  endfunction

  // Monitor: every slave handshake is compared against the scoreboard head.
  initial begin
    txn_t act, e;
    forever begin
      @(negedge clk_sys);
      cyc++;
      m_ack_seen = m_ack;
      if (download_done) done_cnt++;
      if (reset_n && s_stb && s_ack) begin
        hs_cnt++;
        hs_cyc_q.push_back(cyc);
        act.b   = mk(s_adr, s_dat_o, s_we, s_sel, s_cti);
        act.ack = m_ack;
        $display("txn %0d: adr=%h dat=%h we=%0b sel=%h cti=%b m_ack=%b",
                 hs_cnt, s_adr, s_dat_o, s_we, s_sel, s_cti, m_ack);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL txn_unexpected: got %h expected none", act);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("txn%0d", hs_cnt), 128'(act), 128'(e));
          if (!s_we) chk("rd_data", 128'(m_dat_i), 128'(RD_DATA));
        end
      end
    end
  end

  // Master and slave models, updated just after each rising edge.
  initial begin
    beat_t b0, b1;
    forever begin
      @(posedge clk_sys);
      #1;
      if (m_ack_seen[0] && mq0.size() > 0) void'(mq0.pop_front());
      if (m_ack_seen[1] && mq1.size() > 0) void'(mq1.pop_front());
      b0 = (mq0.size() > 0) ? mq0[0] : '0;
      b1 = (mq1.size() > 0) ? mq1[0] : '0;
      m_stb   = {mq1.size() > 0, mq0.size() > 0};
      m_we    = {b1.we, b0.we};
      m_sel   = {b1.sel, b0.sel};
      m_adr   = {b1.adr, b0.adr};
      m_dat_o = {b1.dat, b0.dat};
      m_cti   = {b1.cti, b0.cti};
      s_ack   = ack_en && s_stb;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic ld_write(logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] sel);
    ioctl_addr = a; ioctl_dout = d; ioctl_sel = sel; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_hs(int target, int budget, string name);
    int n;
    n = 0;
    while (hs_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, 128'(hs_cnt), 128'(target));
  endtask

  initial begin
    int h0, d0, q0;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ioctl_sel = '0;
    m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat_o = '0; m_cti = '0;
    s_ack = 1'b0; s_dat_i = RD_DATA;
    repeat (3) @(posedge clk_sys);
    #2;
    chk("reset_outputs", all_outs(), 128'(0));
    reset_n = 1'b1;
    ack_en  = 1'b1;
    tick();

    // Loader single write
    ioctl_download = 1'b1;
    tick();
    expect_txn(mk(26'h001_0000, 32'hDEADBEEF, 1'b1, 4'hF, 3'b000), 2'b00);
    ld_write(26'h001_0003, 32'hDEADBEEF, 4'hF);
    chk("t1_stb_early", 128'(s_stb), 128'(0));
    tick();
    chk("t1_stb", 128'(s_stb), 128'(1));
    chk("t1_adr", 128'(s_adr), 128'(26'h001_0000));
    chk("t1_we", 128'(s_we), 128'(1));
    tick();
    chk("t1_drained", 128'(s_stb), 128'(0));
    d0 = done_cnt;
    ioctl_download = 1'b0;
    repeat (3) tick();
    chk("t1_done_pulse", 128'(done_cnt - d0), 128'(1));

    // Backpressure / overflow with slave stalled
    ack_en = 1'b0;
    ioctl_download = 1'b1;
    expect_txn(mk(26'h100, 32'h1111_0001, 1'b1, 4'hF, 3'b000), 2'b00);
    ld_write(26'h100, 32'h1111_0001, 4'hF);
    chk("t2_wait1", 128'(ioctl_wait), 128'(0));
    expect_txn(mk(26'h104, 32'h2222_0002, 1'b1, 4'h3, 3'b000), 2'b00);
    ld_write(26'h104, 32'h2222_0002, 4'h3);
    chk("t2_wait2", 128'(ioctl_wait), 128'(0));
    expect_txn(mk(26'h108, 32'h3333_0003, 1'b1, 4'hC, 3'b000), 2'b00);
    ld_write(26'h108, 32'h3333_0003, 4'hC);
    chk("t2_wait3", 128'(ioctl_wait), 128'(1));
    expect_txn(mk(26'h10C, 32'h4444_0004, 1'b1, 4'hF, 3'b000), 2'b00);
    ld_write(26'h10C, 32'h4444_0004, 4'hF);
    chk("t2_ovf4", 128'(loader_ovf), 128'(0));
    ld_write(26'h110, 32'h5555_0005, 4'hF);
    chk("t2_ovf5", 128'(loader_ovf), 128'(1));
    chk("t2_head_adr", 128'(s_adr), 128'(26'h100));
    h0 = hs_cnt;
    ack_en = 1'b1;
    repeat (5) tick();
    chk("t2_drain_b2b", 128'(hs_cnt - h0), 128'(4));
    chk("t2_idle", 128'(s_stb), 128'(0));
    chk("t2_wait_clr", 128'(ioctl_wait), 128'(0));
    ioctl_download = 1'b0;
    repeat (2) tick();

    // Round-robin between masters 0 and 1
    h0 = hs_cnt;
    expect_txn(mk(26'h2000, 32'hA0A0_0000, 1'b1, 4'hF, 3'b000), 2'b01);
    expect_txn(mk(26'h3000, 32'hB0B0_0000, 1'b0, 4'hF, 3'b000), 2'b10);
    expect_txn(mk(26'h2010, 32'hA0A0_0001, 1'b1, 4'h1, 3'b000), 2'b01);
    expect_txn(mk(26'h3010, 32'hB0B0_0001, 1'b1, 4'h8, 3'b000), 2'b10);
    mq0.push_back(mk(26'h2000, 32'hA0A0_0000, 1'b1, 4'hF, 3'b000));
    mq0.push_back(mk(26'h2010, 32'hA0A0_0001, 1'b1, 4'h1, 3'b000));
    mq1.push_back(mk(26'h3000, 32'hB0B0_0000, 1'b0, 4'hF, 3'b000));
    mq1.push_back(mk(26'h3010, 32'hB0B0_0001, 1'b1, 4'h8, 3'b000));
    wait_hs(h0 + 4, 60, "t3_rr_done");

    // Burst hold: master 1 keeps the grant for four beats
    h0 = hs_cnt;
    q0 = hs_cyc_q.size();
    for (int i = 0; i < 4; i++) begin
      expect_txn(mk(26'h4000 + 26'(4*i), 32'hC0C0_0000 + i, 1'b0, 4'hF,
                    (i == 3) ? 3'b111 : 3'b010), 2'b10);
      mq1.push_back(mk(26'h4000 + 26'(4*i), 32'hC0C0_0000 + i, 1'b0, 4'hF,
                       (i == 3) ? 3'b111 : 3'b010));
    end
    repeat (3) tick();
    expect_txn(mk(26'h5000, 32'hD0D0_0000, 1'b1, 4'hF, 3'b000), 2'b01);
    mq0.push_back(mk(26'h5000, 32'hD0D0_0000, 1'b1, 4'hF, 3'b000));
    wait_hs(h0 + 5, 60, "t4_burst_done");
    if (hs_cyc_q.size() >= q0 + 5)
      chk("t4_regrant_gap", 128'(hs_cyc_q[q0+4] - hs_cyc_q[q0+3]), 128'(2));

    // Download blocks masters; a loader write preempts
    ioctl_download = 1'b1;
    mq0.push_back(mk(26'h6000, 32'hE0E0_0000, 1'b1, 4'hF, 3'b000));
    h0 = hs_cnt;
    repeat (6) tick();
    chk("t5_blocked", 128'(hs_cnt - h0), 128'(0));
    chk("t5_no_stb", 128'(s_stb), 128'(0));
    expect_txn(mk(26'h7000, 32'h7777_0000, 1'b1, 4'hF, 3'b000), 2'b00);
    expect_txn(mk(26'h6000, 32'hE0E0_0000, 1'b1, 4'hF, 3'b000), 2'b01);
    ld_write(26'h7000, 32'h7777_0000, 4'hF);
    wait_hs(h0 + 1, 20, "t5_loader_first");
    ioctl_download = 1'b0;
    wait_hs(h0 + 2, 20, "t5_master_after");

    // Reset mid-burst with two loader entries buffered
    ack_en = 1'b0;
    mq1.push_back(mk(26'hA000, 32'hF0F0_0000, 1'b1, 4'hF, 3'b010));
    mq1.push_back(mk(26'hA004, 32'hF0F0_0001, 1'b1, 4'hF, 3'b111));
    repeat (3) tick();
    chk("t6_burst_stb", 128'(s_stb), 128'(1));
    chk("t6_burst_cti", 128'(s_cti), 128'(3'b010));
    chk("t6_burst_adr", 128'(s_adr), 128'(26'hA000));
    ioctl_download = 1'b1;
    ld_write(26'hB000, 32'h0B0B_0000, 4'hF);
    ld_write(26'hB004, 32'h0B0B_0001, 4'hF);
    chk("t6_ovf_sticky", 128'(loader_ovf), 128'(1));
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_outputs", all_outs(), 128'(0));
    mq0.delete();
    mq1.delete();
    ioctl_download = 1'b0;
    ack_en = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6_post_rst_idle", 128'(s_stb), 128'(0));
    d0 = done_cnt;
    h0 = hs_cnt;
    expect_txn(mk(26'hC000, 32'h1212_0000, 1'b1, 4'hF, 3'b000), 2'b01);
    expect_txn(mk(26'hD000, 32'h3434_0000, 1'b1, 4'hF, 3'b000), 2'b10);
    mq0.push_back(mk(26'hC000, 32'h1212_0000, 1'b1, 4'hF, 3'b000));
    mq1.push_back(mk(26'hD000, 32'h3434_0000, 1'b1, 4'hF, 3'b000));
    wait_hs(h0 + 2, 30, "t6_post_rst_txns");
    chk("t6_no_done", 128'(done_cnt - d0), 128'(0));

    repeat (3) tick();
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
